// File: rtl/gemm_stream.sv
`default_nettype none
// ============================================================================
// Module   : gemm_stream
// Purpose  : Streaming matrix-vector unit. Computes y = W*x (mod 2^DATA_W) over
//            valid/ready streams. Weights are double-buffered: a shadow buffer
//            is swapped in only after the pipeline drains.
// Options  : GEMM_STREAM_PERF_EN adds perf_vec / perf_stall counters.
// Revision : 1.0
// ============================================================================
module gemm_stream #(
    parameter int SA_SIZE = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [SA_SIZE*DATA_W-1:0] w_row,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SA_SIZE*DATA_W-1:0] in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SA_SIZE*DATA_W-1:0] out_data,
    output logic                      out_last,
`ifdef GEMM_STREAM_PERF_EN
    output logic [31:0]               perf_vec,
    output logic [31:0]               perf_stall,
`endif
    output logic                      busy
);

    localparam int LAT   = 2 * SA_SIZE;
    // The output register is the final stage, so the internal pipe is one shorter.
    localparam int DEPTH = LAT - 1;
    localparam int VEC_W = SA_SIZE * DATA_W;
    localparam int CNT_W = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1;
    localparam int INF_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        NOWT  = 2'd0,
        SWAP  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state;
    logic [VEC_W-1:0] shadow    [SA_SIZE];
    logic [VEC_W-1:0] weights   [SA_SIZE];
    logic [CNT_W-1:0] row_cnt;
    logic             pend;
    logic [VEC_W-1:0] data_pipe [DEPTH];
    logic [DEPTH-1:0] v_pipe;
    logic [DEPTH-1:0] last_pipe;

    logic             stall;
    logic             accept;
    logic             advance;
    logic             w_fire;
    logic             last_beat;
    logic [INF_W-1:0] inflight;
    logic [VEC_W-1:0] product;

    assign stall     = out_valid && !out_ready;
    assign w_ready   = !pend;
    assign in_ready  = (state == RUN) && !stall && !pend;
    assign accept    = in_valid && in_ready;
    assign advance   = !stall && (accept || (inflight != '0) || (state == DRAIN));
    assign w_fire    = w_valid && w_ready;
    assign last_beat = w_fire && (row_cnt == CNT_W'(SA_SIZE - 1));
    assign busy      = (inflight != '0) || out_valid || pend;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < DEPTH; k++) begin
            inflight = inflight + INF_W'(v_pipe[k]);
        end
    end

    // Products are truncated per term; the sum is only needed modulo 2^DATA_W.
    always_comb begin
        logic [DATA_W-1:0] acc;
        acc     = '0;
        product = '0;
        for (int i = 0; i < SA_SIZE; i++) begin
            acc = '0;
            for (int j = 0; j < SA_SIZE; j++) begin
                acc = acc + DATA_W'(weights[i][j*DATA_W +: DATA_W] * in_data[j*DATA_W +: DATA_W]);
            end
            product[i*DATA_W +: DATA_W] = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= NOWT;
            pend    <= 1'b0;
            row_cnt <= '0;
            for (int k = 0; k < SA_SIZE; k++) begin
                shadow[k]  <= '0;
                weights[k] <= '0;
            end
        end else begin
            if (w_fire) begin
                shadow[row_cnt] <= w_row;
                if (last_beat) begin
                    row_cnt <= '0;
                    pend    <= 1'b1;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end
            case (state)
                NOWT: begin
                    if (pend) state <= SWAP;
                end
                SWAP: begin
                    for (int k = 0; k < SA_SIZE; k++) begin
                        weights[k] <= shadow[k];
                        shadow[k]  <= '0;
                    end
                    pend  <= 1'b0;
                    state <= RUN;
                end
                RUN: begin
                    if (pend || last_beat) state <= DRAIN;
                end
                DRAIN: begin
                    if ((inflight == '0) && !out_valid) state <= SWAP;
                end
                default: state <= NOWT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_pipe    <= '0;
            last_pipe <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_pipe[k] <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            if (advance) begin
                for (int k = DEPTH - 1; k > 0; k--) begin
                    data_pipe[k] <= data_pipe[k-1];
                    v_pipe[k]    <= v_pipe[k-1];
                    last_pipe[k] <= last_pipe[k-1];
                end
                data_pipe[0] <= accept ? product : '0;
                v_pipe[0]    <= accept;
                last_pipe[0] <= in_last && accept;
                if (v_pipe[DEPTH-1]) begin
                    out_valid <= 1'b1;
                    out_data  <= data_pipe[DEPTH-1];
                    out_last  <= last_pipe[DEPTH-1];
                end else begin
                    out_valid <= 1'b0;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef GEMM_STREAM_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || (state == SWAP)) begin
            perf_vec   <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready && (perf_vec != '1)) perf_vec <= perf_vec + 32'd1;
            if (stall && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gemm_stream.sv
`default_nettype none
// Self-checking bench for gemm_stream: vector table, scoreboard and corner sequences.
module tb_gemm_stream;

    typedef logic [3:0][31:0] mat_t;
    typedef struct { int wsel; logic [31:0] x; logic [31:0] y; } vec_t;
    typedef struct { logic [31:0] y; logic last; int cyc; } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_row;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
`ifdef GEMM_STREAM_PERF_EN
    logic [31:0] perf_vec;
    logic [31:0] perf_stall;
    logic [31:0] pv0;
    logic [31:0] ps0;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   out_cnt = 0;
    int   stall_cnt = 0;
    int   base_out;
    int   or_mode = 0;
    bit   chk_lat = 0;
    int   cur;
    mat_t bw_active = '0;
    sb_t  sb[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    gemm_stream #(.SA_SIZE(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
`ifdef GEMM_STREAM_PERF_EN
        .perf_vec(perf_vec), .perf_stall(perf_stall),
`endif
        .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] x);
        logic [7:0] acc;
        model = '0;
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc = acc + 8'(bw_active[i][j*8 +: 8] * x[j*8 +: 8]);
            model[i*8 +: 8] = acc;
        end
    endfunction

    function automatic mat_t wmat(input int sel);
        mat_t m;
        for (int i = 0; i < 4; i++) begin
            case (sel)
                0: m[i] = 32'h1 << (8 * i);
                1: m[i] = 32'h01010101;
                2: m[i] = 32'h2 << (8 * i);
                default: begin
                    case (i)
                        0: m[i] = 32'h00000201;
                        1: m[i] = 32'h00000100;
                        2: m[i] = 32'h01000000;
                        default: m[i] = 32'h00010003;
                    endcase
                end
            endcase
        end
        return m;
    endfunction

    task automatic monitor();
        sb_t         e;
        logic        prev_stall = 1'b0;
        logic [32:0] prev_out = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("hold", {out_valid, out_last, out_data}, {1'b1, prev_out});
                if (out_valid && out_ready) begin
                    out_cnt++;
                    if (sb.size() == 0) begin
                        check("unexpected_out", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_data", {out_last, out_data}, {e.last, e.y});
                        if (chk_lat) check("latency", cyc - e.cyc, 8);
                    end
                end
                if (out_valid && !out_ready) stall_cnt++;
                if (in_valid && in_ready) begin
                    e.y = model(in_data);
                    e.last = in_last;
                    e.cyc = cyc;
                    sb.push_back(e);
                end
                prev_stall = out_valid && !out_ready;
                prev_out = {out_last, out_data};
            end
        end
    endtask

    task automatic drive_ready();
        int         idx = 0;
        logic [3:0] pat = 4'b1001;
        forever begin
            @(posedge clk);
            #1;
            if (or_mode == 1) begin
                out_ready = pat[idx % 4];
                idx++;
            end else begin
                out_ready = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rows(input mat_t m, input int first, input int n, input bit commit);
        bit ok;
        for (int r = first; r < first + n; r++) begin
            w_valid = 1'b1;
            w_row = m[r];
            ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                @(negedge clk);
                ok = w_ready;
                tick();
            end
            if (!ok) check("w_timeout", ok, 1);
        end
        w_valid = 1'b0;
        if (commit) bw_active = m;
    endtask

    task automatic send(input logic [31:0] x, input bit last);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data = x;
        in_last = last;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        if (!ok) check("send_timeout", ok, 1);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_in_ready(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        if (!ok) check(name, ok, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = (sb.size() == 0) && !busy && !out_valid;
            tick();
        end
        if (!ok) check("idle_timeout", ok, 1);
    endtask

    task automatic expect_out(input string name, input logic [31:0] y);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check(name, out_data, y);
            end
            tick();
        end
        if (!seen) check({name, "_timeout"}, seen, 1);
    endtask

    initial begin
        tbl[0] = '{0, 32'h04030201, 32'h04030201};
        tbl[1] = '{0, 32'h08070605, 32'h08070605};
        tbl[2] = '{0, 32'h007F80FF, 32'h007F80FF};
        tbl[3] = '{1, 32'h0000017F, 32'h80808080};
        tbl[4] = '{1, 32'h04030201, 32'h0A0A0A0A};
        tbl[5] = '{1, 32'h0000FFFF, 32'hFEFEFEFE};
        tbl[6] = '{2, 32'h01010101, 32'h02020202};
        tbl[7] = '{2, 32'h7F400380, 32'hFE800600};

        reset = 1'b1; w_valid = 1'b0; w_row = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        fork
            monitor();
            drive_ready();
        join_none
        repeat (3) tick();
        reset = 1'b0;

        // No weights loaded: input must be refused and nothing may come out
        @(negedge clk);
        check("rst_outs", {out_valid, out_last, busy, in_ready, out_data}, 0);
        tick();
        in_valid = 1'b1;
        in_data = 32'h11223344;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t1_idle", {in_ready, busy, out_valid}, 0);
            tick();
        end
        in_valid = 1'b0;

        // Identity weights, two back-to-back vectors with exact latency
        load_rows(wmat(0), 0, 4, 1);
        wait_in_ready("t2_ready");
        chk_lat = 1'b1;
        send(32'h04030201, 1'b0);
        send(32'h08070605, 1'b1);
        wait_idle();
        chk_lat = 1'b0;

        cur = 0;
        foreach (tbl[n]) begin
            if (tbl[n].wsel != cur) begin
                cur = tbl[n].wsel;
                load_rows(wmat(cur), 0, 4, 1);
                wait_in_ready("tbl_ready");
            end
            send(tbl[n].x, 1'b0);
            expect_out($sformatf("tbl%0d", n), tbl[n].y);
        end
        wait_idle();

        // Ten vectors under a 1,0,0,1 out_ready pattern
        load_rows(wmat(3), 0, 4, 1);
        wait_in_ready("t4_ready");
        base_out = out_cnt;
        stall_cnt = 0;
`ifdef GEMM_STREAM_PERF_EN
        pv0 = perf_vec;
        ps0 = perf_stall;
`endif
        or_mode = 1;
        for (int n = 0; n < 10; n++) send($urandom, n == 9);
        wait_idle();
        or_mode = 0;
        check("t4_count", out_cnt - base_out, 10);
`ifdef GEMM_STREAM_PERF_EN
        check("t4_perf_vec", perf_vec - pv0, 10);
        check("t4_perf_stall", perf_stall - ps0, stall_cnt);
`endif

        // Weight reload while three vectors are in flight
        load_rows(wmat(0), 0, 4, 1);
        wait_in_ready("t5_ready0");
        send(32'h04030201, 1'b0);
        send(32'h05040302, 1'b0);
        send(32'h06070809, 1'b0);
        load_rows(wmat(2), 0, 4, 1);
        @(negedge clk);
        check("t5_block", {in_ready, busy}, 2'b01);
        tick();
        wait_in_ready("t5_ready1");
        check("t5_drained", sb.size(), 0);
        send(32'h01010101, 1'b0);
        expect_out("t5_y", 32'h02020202);
        wait_idle();

        // Reset with vectors in flight and a partial shadow load
        load_rows(wmat(3), 0, 2, 0);
        for (int n = 0; n < 5; n++) send($urandom, 1'b0);
        @(negedge clk);
        check("t6_busy", busy, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t6_quiet", {out_valid, in_ready, busy}, 0);
            tick();
        end
        load_rows(wmat(3), 0, 3, 0);
        repeat (6) tick();
        @(negedge clk);
        check("t6_partial", in_ready, 0);
        tick();
        load_rows(wmat(3), 3, 1, 1);
        wait_in_ready("t6_ready");
        send(32'h04030201, 1'b0);
        expect_out("t6_y", 32'h06040205);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
